// File: rtl/result_queue_arbiter.sv
// Round-robin arbiter merging NUM_REQ producer bursts into one result queue write port.
// Define RESULT_QUEUE_ARBITER_GRANT_COUNT_EN to build the per-producer saturating beat counters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no grant; pick next valid producer after the pointer
//   S_GRANT | grant_id owns the write port until last or MAX_BURST beats
module result_queue_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rq_we,
    output logic [WIDTH-1:0]             rq_data,
    input  logic                         rq_full,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [NUM_REQ*16-1:0]        grant_count
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);
    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] gid_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic [CW-1:0]  cnt, cnt_n, cnt_inc;
    logic           found;
    logic           beat;
    logic           cur_valid;
    logic           cur_last;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Reset gates the beat so an abandoned burst writes nothing in the reset cycle.
    assign cur_valid = req_valid[grant_id];
    assign cur_last  = req_last[grant_id];
    assign beat      = (state == S_GRANT) && cur_valid && !rq_full && !reset;
    assign cnt_inc   = cnt + 1'b1;

    assign rq_we   = beat;
    assign busy    = (state == S_GRANT);
    assign rq_data = req_data[grant_id*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (beat) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        gid_n   = grant_id;
        cnt_n   = cnt;
        ptr_n   = ptr;
        case (state)
            S_IDLE: begin
                if (found) begin
                    gid_n   = pick;
                    cnt_n   = '0;
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (beat) begin
                    cnt_n = cnt_inc;
                    if (cur_last || (cnt_inc == CNT_MAX)) begin
                        state_n = S_IDLE;
                        ptr_n   = grant_id;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            grant_id <= '0;
            cnt      <= '0;
            ptr      <= PTR_RST;
        end else begin
            state    <= state_n;
            grant_id <= gid_n;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
        end
    end

`ifdef RESULT_QUEUE_ARBITER_GRANT_COUNT_EN
    logic [15:0] gcnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (gcnt[i] != 16'hFFFF)) begin
                    gcnt[i] <= gcnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count[i*16 +: 16] = gcnt[i];
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_result_queue_arbiter.sv
// Directed bench for result_queue_arbiter: arbitration, fairness, burst cap, stall, reset, counters.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled on the falling edge.
module tb_result_queue_arbiter;

    logic          clk;
    logic          reset;
    logic [3:0]    req_valid;
    logic [127:0]  req_data;
    logic [3:0]    req_last;
    logic [3:0]    req_ready;
    logic          rq_we;
    logic [31:0]   rq_data;
    logic          rq_full;
    logic [1:0]    grant_id;
    logic          busy;
    logic [63:0]   grant_count;

    int total = 0;
    int bad   = 0;

    // Producer model: word k of producer p carries {p+1, k}.
    int          nwords [4];
    int          idx [4];
    logic [15:0] last_mask [4];
    bit          stream [4];
    int          nbeats;

    logic        cur_we;
    logic [31:0] cur_data;
    logic [3:0]  cur_ready;
    logic        cur_busy;
    logic [1:0]  cur_gid;
    logic [63:0] cur_gc;

    result_queue_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .rq_we(rq_we), .rq_data(rq_data),
        .rq_full(rq_full), .grant_id(grant_id), .busy(busy), .grant_count(grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        for (int p = 0; p < 4; p++) begin
            req_data[p*32 +: 32] = {4'(p + 1), 28'(idx[p])};
            if (stream[p]) begin
                req_valid[p] = 1'b1;
                req_last[p]  = 1'b0;
            end else if (idx[p] < nwords[p]) begin
                req_valid[p] = 1'b1;
                req_last[p]  = last_mask[p][idx[p]];
            end else begin
                req_valid[p] = 1'b0;
                req_last[p]  = 1'b0;
            end
        end
        @(negedge clk);
        cur_we    = rq_we;
        cur_data  = rq_data;
        cur_ready = req_ready;
        cur_busy  = busy;
        cur_gid   = grant_id;
        cur_gc    = grant_count;
        for (int p = 0; p < 4; p++) begin
            if (req_ready[p]) idx[p]++;
        end
        if (rq_we) nbeats++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rq_full = 1'b0;
        nbeats  = 0;
        for (int p = 0; p < 4; p++) begin
            nwords[p] = 0; idx[p] = 0; last_mask[p] = '0; stream[p] = 1'b0;
        end
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rq_full = 1'b0;
        for (int p = 0; p < 4; p++) begin
            nwords[p] = 0; idx[p] = 0; last_mask[p] = '0; stream[p] = 1'b0;
        end
        stream[2] = 1'b1;
        cycle();
        cycle();
        total++; if (cur_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", cur_we); end
        total++; if (cur_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", cur_ready); end
        total++; if (cur_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", cur_busy); end
        total++; if (cur_gid !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d want=0", cur_gid); end
        total++; if (cur_gc !== 64'd0) begin bad++; $display("FAIL reset_gc got=%h want=0", cur_gc); end
        reset = 1'b0;
        cycle();
        total++; if (cur_busy !== 1'b0) begin bad++; $display("FAIL reset_arb_busy got=%b want=0", cur_busy); end
        cycle();
        total++; if (cur_gid !== 2'd2 || cur_we !== 1'b1) begin
            bad++; $display("FAIL reset_first_grant gid=%0d we=%b want gid=2 we=1", cur_gid, cur_we);
        end
    endtask

    task automatic test_basic();
        logic [4:0]  we_p;
        logic [31:0] ed [5];
        we_p = 5'b00110;
        ed[0] = 32'h0; ed[1] = 32'h1000_0000; ed[2] = 32'h1000_0001; ed[3] = 32'h0; ed[4] = 32'h0;
        do_reset();
        nwords[0] = 2; last_mask[0] = 16'b10;
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++; if (cur_we !== we_p[k]) begin bad++; $display("FAIL basic_we k=%0d got=%b want=%b", k, cur_we, we_p[k]); end
            total++; if (cur_busy !== we_p[k]) begin bad++; $display("FAIL basic_busy k=%0d got=%b want=%b", k, cur_busy, we_p[k]); end
            total++; if (cur_ready !== (we_p[k] ? 4'b0001 : 4'b0000)) begin
                bad++; $display("FAIL basic_ready k=%0d got=%b", k, cur_ready);
            end
            if (we_p[k]) begin
                total++; if (cur_data !== ed[k]) begin bad++; $display("FAIL basic_data k=%0d got=%h want=%h", k, cur_data, ed[k]); end
            end
        end
`ifdef RESULT_QUEUE_ARBITER_GRANT_COUNT_EN
        total++; if (cur_gc !== 64'h0000_0000_0000_0002) begin bad++; $display("FAIL basic_gc got=%h want=2", cur_gc); end
`else
        total++; if (cur_gc !== 64'd0) begin bad++; $display("FAIL basic_gc_off got=%h want=0", cur_gc); end
`endif
    endtask

    task automatic test_round_robin();
        logic [1:0]  eg [5];
        logic [31:0] ed [5];
        int j;
        eg[0] = 2'd0; eg[1] = 2'd1; eg[2] = 2'd2; eg[3] = 2'd3; eg[4] = 2'd0;
        ed[0] = 32'h1000_0000; ed[1] = 32'h2000_0000; ed[2] = 32'h3000_0000;
        ed[3] = 32'h4000_0000; ed[4] = 32'h1000_0001;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            nwords[p] = 2; last_mask[p] = 16'hFFFF;
        end
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k % 2 == 1) begin
                j = (k - 1) / 2;
                total++; if (cur_we !== 1'b1 || cur_gid !== eg[j]) begin
                    bad++; $display("FAIL rr_grant k=%0d we=%b gid=%0d want we=1 gid=%0d", k, cur_we, cur_gid, eg[j]);
                end
                total++; if (cur_data !== ed[j]) begin bad++; $display("FAIL rr_data k=%0d got=%h want=%h", k, cur_data, ed[j]); end
                total++; if (cur_ready !== (4'b0001 << eg[j])) begin bad++; $display("FAIL rr_ready k=%0d got=%b", k, cur_ready); end
            end else begin
                total++; if (cur_we !== 1'b0 || cur_busy !== 1'b0) begin
                    bad++; $display("FAIL rr_idle k=%0d we=%b busy=%b want 0 0", k, cur_we, cur_busy);
                end
            end
        end
`ifdef RESULT_QUEUE_ARBITER_GRANT_COUNT_EN
        cycle();
        total++; if (cur_gc !== 64'h0001_0001_0001_0002) begin bad++; $display("FAIL rr_gc got=%h want=0001000100010002", cur_gc); end
`endif
    endtask

    task automatic test_burst_cap();
        logic [9:0]  we_p;
        logic [9:0]  busy_p;
        logic [31:0] ed [10];
        we_p   = 10'b0011011110;
        busy_p = 10'b1111011110;
        ed[0] = 32'h0;         ed[1] = 32'h3000_0000; ed[2] = 32'h3000_0001; ed[3] = 32'h3000_0002;
        ed[4] = 32'h3000_0003; ed[5] = 32'h0;         ed[6] = 32'h3000_0004; ed[7] = 32'h3000_0005;
        ed[8] = 32'h3000_0006; ed[9] = 32'h3000_0006;
        do_reset();
        nwords[2] = 6;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) begin
                nwords[0] = 1; last_mask[0] = 16'h1;
            end
            cycle();
            total++; if (cur_we !== we_p[k]) begin bad++; $display("FAIL cap_we k=%0d got=%b want=%b", k, cur_we, we_p[k]); end
            total++; if (cur_busy !== busy_p[k]) begin bad++; $display("FAIL cap_busy k=%0d got=%b want=%b", k, cur_busy, busy_p[k]); end
            total++; if (cur_ready !== (we_p[k] ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL cap_ready k=%0d got=%b", k, cur_ready); end
            if (busy_p[k]) begin
                total++; if (cur_gid !== 2'd2 || cur_data !== ed[k]) begin
                    bad++; $display("FAIL cap_data k=%0d gid=%0d data=%h want gid=2 data=%h", k, cur_gid, cur_data, ed[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] we_p;
        logic [11:0] busy_p;
        logic [31:0] ed [12];
        we_p   = 12'b011011100010;
        busy_p = 12'b111011111110;
        ed[0]  = 32'h0;         ed[1]  = 32'h2000_0000; ed[2]  = 32'h2000_0001; ed[3]  = 32'h2000_0001;
        ed[4]  = 32'h2000_0001; ed[5]  = 32'h2000_0001; ed[6]  = 32'h2000_0002; ed[7]  = 32'h2000_0003;
        ed[8]  = 32'h0;         ed[9]  = 32'h2000_0004; ed[10] = 32'h2000_0005; ed[11] = 32'h2000_0006;
        do_reset();
        nwords[1] = 6;
        for (int k = 0; k < 12; k++) begin
            rq_full = (k >= 2 && k <= 4);
            cycle();
            total++; if (cur_we !== we_p[k]) begin bad++; $display("FAIL bp_we k=%0d got=%b want=%b", k, cur_we, we_p[k]); end
            total++; if (cur_busy !== busy_p[k]) begin bad++; $display("FAIL bp_busy k=%0d got=%b want=%b", k, cur_busy, busy_p[k]); end
            total++; if (cur_ready !== (we_p[k] ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL bp_ready k=%0d got=%b", k, cur_ready); end
            if (busy_p[k]) begin
                total++; if (cur_data !== ed[k]) begin bad++; $display("FAIL bp_data k=%0d got=%h want=%h", k, cur_data, ed[k]); end
            end
        end
        rq_full = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        nwords[3] = 4; last_mask[3] = 16'b1000;
        cycle();
        cycle();
        total++; if (cur_we !== 1'b1 || cur_gid !== 2'd3 || cur_data !== 32'h4000_0000) begin
            bad++; $display("FAIL rmb_first we=%b gid=%0d data=%h want 1 3 40000000", cur_we, cur_gid, cur_data);
        end
        reset = 1'b1;
        cycle();
        total++; if (cur_we !== 1'b0 || cur_ready !== 4'b0000) begin
            bad++; $display("FAIL rmb_in_reset we=%b ready=%b want 0 0000", cur_we, cur_ready);
        end
        reset = 1'b0;
        nwords[0] = 1; last_mask[0] = 16'h1;
        cycle();
        total++; if (cur_busy !== 1'b0 || cur_we !== 1'b0 || cur_gid !== 2'd0) begin
            bad++; $display("FAIL rmb_after busy=%b we=%b gid=%0d want 0 0 0", cur_busy, cur_we, cur_gid);
        end
        total++; if (cur_gc !== 64'd0) begin bad++; $display("FAIL rmb_gc got=%h want=0", cur_gc); end
        cycle();
        total++; if (cur_we !== 1'b1 || cur_gid !== 2'd0 || cur_data !== 32'h1000_0000) begin
            bad++; $display("FAIL rmb_next_grant we=%b gid=%0d data=%h want 1 0 10000000", cur_we, cur_gid, cur_data);
        end
        cycle();
        cycle();
        total++; if (cur_we !== 1'b1 || cur_gid !== 2'd3 || cur_data !== 32'h4000_0001) begin
            bad++; $display("FAIL rmb_retained we=%b gid=%0d data=%h want 1 3 40000001", cur_we, cur_gid, cur_data);
        end
    endtask

`ifdef RESULT_QUEUE_ARBITER_GRANT_COUNT_EN
    task automatic test_saturation();
        int cyc;
        do_reset();
        stream[1] = 1'b1;
        cyc = 0;
        while (nbeats < 70000 && cyc < 95000) begin
            cycle();
            cyc++;
        end
        stream[1] = 1'b0;
        cycle();
        total++; if (nbeats < 70000) begin bad++; $display("FAIL sat_timeout beats=%0d want=70000", nbeats); end
        total++; if (cur_gc[31:16] !== 16'hFFFF) begin bad++; $display("FAIL sat_p1 got=%h want=ffff", cur_gc[31:16]); end
        total++; if (cur_gc[15:0] !== 16'h0 || cur_gc[63:32] !== 32'h0) begin
            bad++; $display("FAIL sat_others got=%h want=0", {cur_gc[63:32], cur_gc[15:0]});
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        rq_full   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        nbeats    = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_reset_mid_burst();
`ifdef RESULT_QUEUE_ARBITER_GRANT_COUNT_EN
        test_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
